// File: rtl/branch_resolve_unit_if.sv
// Signal bundle between execute/fetch and the branch resolve unit.
// The stat_* counters exist only when BRANCH_STATS_EN is defined.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pred_pc;
    logic            pred_taken;

    logic            ex_valid;
    logic            ex_branch;
    logic            ex_jump;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_operand1;
    logic [XLEN-1:0] ex_operand2;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic            flush;

    logic            res_valid;
    logic            res_taken;
    logic            res_mispredict;
    logic [XLEN-1:0] res_redirect_pc;
    logic            res_illegal;
`ifdef BRANCH_STATS_EN
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;
`endif

    // Handshake: no backpressure. A cycle with ex_valid=1 and flush=0 carrying a
    // branch or jump is consumed unconditionally; res_valid pulses for exactly one
    // cycle, one clock later, and res_* fields are meaningful only while it is high.
    modport master (
        output pred_pc, ex_valid, ex_branch, ex_jump, ex_funct3, ex_operand1,
               ex_operand2, ex_pc, ex_target, ex_pred_taken, flush,
`ifdef BRANCH_STATS_EN
        input  stat_branches, stat_mispredicts,
`endif
        input  pred_taken, res_valid, res_taken, res_mispredict, res_redirect_pc,
               res_illegal
    );

    modport slave (
        input  pred_pc, ex_valid, ex_branch, ex_jump, ex_funct3, ex_operand1,
               ex_operand2, ex_pc, ex_target, ex_pred_taken, flush,
`ifdef BRANCH_STATS_EN
        output stat_branches, stat_mispredicts,
`endif
        output pred_taken, res_valid, res_taken, res_mispredict, res_redirect_pc,
               res_illegal
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates branch/jump outcomes at execute (registered result)
// and predicts at fetch from a bimodal 2-bit counter table. Optional: BRANCH_STATS_EN.
module branch_resolve_unit #(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] CTR_INIT    = 2'b01
) (
    input logic clk,
    input logic rst,
    branch_resolve_unit_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;

    logic cond_taken;
    logic funct3_bad;
    logic taken;
    logic illegal;
    logic live;
    logic update_en;
    logic mispredict;
    logic [XLEN-1:0] redirect_pc;

    assign pred_idx       = bus.pred_pc[IDX_W+1:2];
    assign upd_idx        = bus.ex_pc[IDX_W+1:2];
    assign bus.pred_taken = bht[pred_idx][1];

    // Only the index bits of the fetch PC select a counter; there is no tag.
    logic unused_pred_pc_bits;
    assign unused_pred_pc_bits = ^{bus.pred_pc[XLEN-1:IDX_W+2], bus.pred_pc[1:0]};

    always_comb begin
        cond_taken = 1'b0;
        funct3_bad = 1'b0;
        case (bus.ex_funct3)
            3'b000:  cond_taken = (bus.ex_operand1 == bus.ex_operand2);
            3'b001:  cond_taken = (bus.ex_operand1 != bus.ex_operand2);
            3'b100:  cond_taken = ($signed(bus.ex_operand1) <  $signed(bus.ex_operand2));
            3'b101:  cond_taken = ($signed(bus.ex_operand1) >= $signed(bus.ex_operand2));
            3'b110:  cond_taken = (bus.ex_operand1 <  bus.ex_operand2);
            3'b111:  cond_taken = (bus.ex_operand1 >= bus.ex_operand2);
            default: funct3_bad = 1'b1;
        endcase
    end

    // A jump overrides any branch decoding on the same instruction.
    assign taken       = bus.ex_jump | (bus.ex_branch & cond_taken);
    assign illegal     = ~bus.ex_jump & bus.ex_branch & funct3_bad;
    assign live        = bus.ex_valid & ~bus.flush & (bus.ex_branch | bus.ex_jump);
    assign update_en   = live & bus.ex_branch & ~bus.ex_jump & ~funct3_bad;
    assign mispredict  = (taken != bus.ex_pred_taken);
    assign redirect_pc = taken ? bus.ex_target : bus.ex_pc + XLEN'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.res_valid       <= 1'b0;
            bus.res_taken       <= 1'b0;
            bus.res_mispredict  <= 1'b0;
            bus.res_illegal     <= 1'b0;
            bus.res_redirect_pc <= '0;
        end else begin
            bus.res_valid      <= live;
            bus.res_taken      <= live & taken;
            bus.res_mispredict <= live & mispredict;
            bus.res_illegal    <= live & illegal;
            if (live) begin
                bus.res_redirect_pc <= redirect_pc;
            end
        end
    end

    // Read-before-write: pred_taken sees the old counter during the update cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= CTR_INIT;
            end
        end else if (update_en) begin
            if (cond_taken) begin
                if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'b01;
            end else begin
                if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'b01;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.stat_branches    <= '0;
            bus.stat_mispredicts <= '0;
        end else if (live) begin
            bus.stat_branches <= bus.stat_branches + 32'd1;
            if (mispredict) bus.stat_mispredicts <= bus.stat_mispredicts + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: table of condition vectors plus hand-written
// sequences for counter training, saturation, flush, jumps, illegal codes and reset.
module tb_branch_resolve_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(32)) bus ();

    branch_resolve_unit #(
        .XLEN(32),
        .BHT_ENTRIES(64),
        .CTR_INIT(2'b01)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int exp_br = 0;
    int exp_mis = 0;

    typedef struct {
        string       name;
        logic        br;
        logic        jmp;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        pred;
        logic        e_taken;
        logic        e_mis;
        logic        e_ill;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ex_valid      = 1'b0;
        bus.ex_branch     = 1'b0;
        bus.ex_jump       = 1'b0;
        bus.ex_funct3     = 3'b000;
        bus.ex_operand1   = '0;
        bus.ex_operand2   = '0;
        bus.ex_pc         = '0;
        bus.ex_target     = '0;
        bus.ex_pred_taken = 1'b0;
        bus.flush         = 1'b0;
    endtask

    task automatic drive(input logic br, input logic jmp, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic pred);
        bus.ex_valid      = 1'b1;
        bus.flush         = 1'b0;
        bus.ex_branch     = br;
        bus.ex_jump       = jmp;
        bus.ex_funct3     = f3;
        bus.ex_operand1   = a;
        bus.ex_operand2   = b;
        bus.ex_pc         = pc;
        bus.ex_target     = tgt;
        bus.ex_pred_taken = pred;
    endtask

    // Checks one result cycle; a valid expectation is also counted for the stats model.
    task automatic check_res(input string name, input logic v, input logic t, input logic m,
                             input logic i, input logic [31:0] rpc);
        check({name, ".valid"}, 32'(bus.res_valid), 32'(v));
        check({name, ".taken"}, 32'(bus.res_taken), 32'(t));
        check({name, ".mispredict"}, 32'(bus.res_mispredict), 32'(m));
        check({name, ".illegal"}, 32'(bus.res_illegal), 32'(i));
        check({name, ".redirect"}, bus.res_redirect_pc, rpc);
        if (v) exp_br++;
        if (v && m) exp_mis++;
    endtask

    task automatic check_pred(input string name, input logic [31:0] pc, input logic exp);
        bus.pred_pc = pc;
        #1;
        check(name, 32'(bus.pred_taken), 32'(exp));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_br  = 0;
        exp_mis = 0;
    endtask

    initial begin
        vecs[0]  = '{"blt_neg",   1, 0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h1000, 32'h2000, 0, 1, 1, 0, 32'h2000};
        vecs[1]  = '{"bltu_big",  1, 0, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h1010, 32'h2010, 0, 0, 0, 0, 32'h1014};
        vecs[2]  = '{"bge_eq",    1, 0, 3'b101, 32'h7, 32'h7, 32'h1020, 32'h2020, 1, 1, 0, 0, 32'h2020};
        vecs[3]  = '{"bgeu_eq",   1, 0, 3'b111, 32'h7, 32'h7, 32'h1030, 32'h2030, 0, 1, 1, 0, 32'h2030};
        vecs[4]  = '{"bne_diff",  1, 0, 3'b001, 32'h3, 32'h4, 32'h1040, 32'h2040, 1, 1, 0, 0, 32'h2040};
        vecs[5]  = '{"bne_eq",    1, 0, 3'b001, 32'h9, 32'h9, 32'h1050, 32'h2050, 1, 0, 1, 0, 32'h1054};
        vecs[6]  = '{"blt_pos",   1, 0, 3'b100, 32'h1, 32'hFFFF_FFFF, 32'h1060, 32'h2060, 0, 0, 0, 0, 32'h1064};
        vecs[7]  = '{"bge_neg",   1, 0, 3'b101, 32'hFFFF_FFFB, 32'h3, 32'h1070, 32'h2070, 1, 0, 1, 0, 32'h1074};
        vecs[8]  = '{"bltu_small",1, 0, 3'b110, 32'h1, 32'hFFFF_FFFF, 32'h1080, 32'h2080, 0, 1, 1, 0, 32'h2080};
        vecs[9]  = '{"bgeu_big",  1, 0, 3'b111, 32'hFFFF_FFFF, 32'h1, 32'h1090, 32'h2090, 1, 1, 0, 0, 32'h2090};
        vecs[10] = '{"beq_diff",  1, 0, 3'b000, 32'h1, 32'h2, 32'h10A0, 32'h20A0, 0, 0, 0, 0, 32'h10A4};
        vecs[11] = '{"jal",       0, 1, 3'b011, 32'h0, 32'h0, 32'h10B0, 32'h20B0, 0, 1, 1, 0, 32'h20B0};
        vecs[12] = '{"jump_br",   1, 1, 3'b010, 32'h3, 32'h3, 32'h10C0, 32'h20C0, 1, 1, 0, 0, 32'h20C0};
        vecs[13] = '{"ill_010",   1, 0, 3'b010, 32'h3, 32'h3, 32'h10D0, 32'h20D0, 1, 0, 1, 1, 32'h10D4};
        vecs[14] = '{"ill_011",   1, 0, 3'b011, 32'h3, 32'h3, 32'h10E0, 32'h20E0, 0, 0, 0, 1, 32'h10E4};
        vecs[15] = '{"pc_wrap",   1, 0, 3'b000, 32'h1, 32'h2, 32'hFFFF_FFFC, 32'h20F0, 0, 0, 0, 0, 32'h0000_0000};

        idle();
        bus.pred_pc = 32'h100;
        do_reset();
        check_res("reset", 0, 0, 0, 0, 32'h0);
        check_pred("pred_after_reset", 32'h100, 1'b0);

        // First training step; prediction at the same index still shows the old value.
        drive(1, 0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h180, 1'b0);
        check_pred("pred_same_cycle", 32'h100, 1'b0);
        tick();
        idle();
        check_res("beq_first", 1, 1, 1, 0, 32'h180);
        check_pred("pred_trained", 32'h100, 1'b1);
        tick();
        check_res("idle_hold", 0, 0, 0, 0, 32'h180);

        for (int k = 0; k < 16; k++) begin
            drive(vecs[k].br, vecs[k].jmp, vecs[k].f3, vecs[k].a, vecs[k].b,
                  vecs[k].pc, vecs[k].tgt, vecs[k].pred);
            tick();
            check_res(vecs[k].name, 1, vecs[k].e_taken, vecs[k].e_mis, vecs[k].e_ill,
                      vecs[k].e_rpc);
        end
        idle();

        // Reset asserted together with a live taken branch on a trained counter.
        do_reset();
        drive(1, 0, 3'b000, 32'd1, 32'd1, 32'h300, 32'h380, 1'b0);
        tick();
        drive(1, 0, 3'b000, 32'd1, 32'd1, 32'h300, 32'h380, 1'b0);
        tick();
        check_pred("pred_pre_rst", 32'h300, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_br  = 0;
        exp_mis = 0;
        idle();
        check_res("rst_mid", 0, 0, 0, 0, 32'h0);
        check_pred("pred_post_rst", 32'h300, 1'b0);

        // Saturation at 0x200: four taken then two not-taken.
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 3'b000, 32'd2, 32'd2, 32'h200, 32'h280, 1'b1);
            tick();
            idle();
            check_res("sat_taken", 1, 1, 0, 0, 32'h280);
            check_pred("sat_pred_t", 32'h200, 1'b1);
        end
        drive(1, 0, 3'b000, 32'd2, 32'd3, 32'h200, 32'h280, 1'b1);
        tick();
        idle();
        check_res("sat_nt1", 1, 0, 1, 0, 32'h204);
        check_pred("sat_pred_nt1", 32'h200, 1'b1);
        drive(1, 0, 3'b000, 32'd2, 32'd3, 32'h200, 32'h280, 1'b1);
        tick();
        idle();
        check_res("sat_nt2", 1, 0, 1, 0, 32'h204);
        check_pred("sat_pred_nt2", 32'h200, 1'b0);

        // Flushed taken BNE must neither resolve nor train.
        drive(1, 0, 3'b001, 32'd1, 32'd2, 32'h200, 32'h280, 1'b0);
        bus.flush = 1'b1;
        tick();
        idle();
        check_res("flush", 0, 0, 0, 0, 32'h204);
        check_pred("flush_no_upd", 32'h200, 1'b0);

        // Invalid taken branch: no result, no training.
        drive(1, 0, 3'b000, 32'd1, 32'd1, 32'h200, 32'h280, 1'b0);
        bus.ex_valid = 1'b0;
        tick();
        idle();
        check_res("invalid", 0, 0, 0, 0, 32'h204);
        check_pred("invalid_no_upd", 32'h200, 1'b0);

        // JAL does not train the table.
        drive(0, 1, 3'b000, 32'd0, 32'd0, 32'h200, 32'h400, 1'b0);
        tick();
        idle();
        check_res("jal_seq", 1, 1, 1, 0, 32'h400);
        check_pred("jal_no_upd", 32'h200, 1'b0);

        // Raise counter to 10, then an illegal code must leave it there.
        drive(1, 0, 3'b000, 32'd4, 32'd4, 32'h200, 32'h280, 1'b0);
        tick();
        idle();
        check_res("retrain", 1, 1, 1, 0, 32'h280);
        check_pred("retrain_pred", 32'h200, 1'b1);
        drive(1, 0, 3'b010, 32'd4, 32'd5, 32'h200, 32'h280, 1'b1);
        tick();
        idle();
        check_res("ill_seq", 1, 0, 1, 1, 32'h204);
        check_pred("ill_no_upd", 32'h200, 1'b1);

`ifdef BRANCH_STATS_EN
        check("stat_branches", bus.stat_branches, 32'(exp_br));
        check("stat_mispredicts", bus.stat_mispredicts, 32'(exp_mis));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
